// File: rtl/instr_encoder.sv
// instr_encoder: assembles field-level RV64 instruction requests into words and streams them into instruction memory
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [63:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic [7:0]        err_count
);
  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);
  state_t            state_q, state_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              full_q, full_d, err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [6:0]        opcode;
  logic [31:0]       enc;
  logic              imm_ok, legal;
  // encode the request and decide whether it is legal
  always_comb begin
    opcode = fmt == 3'd0 ? 7'b0110011 :
             fmt == 3'd1 ? 7'b0010011 :
             fmt == 3'd2 ? 7'b0000011 :
             fmt == 3'd3 ? 7'b0100011 : 7'b1100011;
    enc = fmt == 3'd0 ? {funct7, rs2, rs1, funct3, rd, opcode} :
          fmt == 3'd3 ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
          fmt == 3'd4 ? {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode} :
                        {imm[11:0], rs1, funct3, rd, opcode};
    imm_ok = (&imm[63:11]) | ~(|imm[63:11]);
    legal  = fmt <= 3'd4 && (fmt == 3'd0 || imm_ok);
  end
  assign in_ready   = state_q == IDLE && !full_q;
  assign mem_we     = state_q == WRITE && !clear;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = word_count_q;
  assign full       = full_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
  // next-state: accept in IDLE, commit in WRITE, record the rejection in DROP; clear overrides all
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    full_d       = full_q;
    err_d        = err_q;
    err_count_d  = err_count_q;
    if (clear) begin
      state_d      = IDLE;
      word_count_d = '0;
      addr_d       = BASE;
      full_d       = 1'b0;
      err_d        = 1'b0;
      err_count_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          wdata_d = enc;
          state_d = legal ? WRITE : DROP;
        end
        WRITE: begin
          word_count_d = word_count_q + (ADDR_W+1)'(1);
          addr_d       = addr_q + ADDR_W'(1);
          full_d       = word_count_q + (ADDR_W+1)'(1) == LIMIT;
          state_d      = IDLE;
        end
        DROP: begin
          err_d       = 1'b1;
          err_count_d = err_count_q == 8'hff ? 8'hff : err_count_q + 8'd1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      addr_q       <= BASE;
      wdata_q      <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      full_q       <= full_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random-field checks of instr_encoder
module tb_instr_encoder;
  localparam int AW = 8, DEP = 4, BASE = 16;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0;
  logic in_ready, mem_we, full, err;
  logic [2:0] fmt = 0, funct3 = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [6:0] funct7 = 0;
  logic [63:0] imm = 0;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [AW:0] word_count;
  logic [7:0] err_count;
  int n_chk = 0, n_pass = 0, consec = 0, b = 0;
  logic prev_we = 0;
  logic [AW-1:0] wa[$];
  logic [31:0] wd[$];

  instr_encoder #(.ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .full(full), .err(err), .err_count(err_count));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (mem_we && prev_we) consec++;
    prev_we = mem_we;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [63:0] im);
    int w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    if (w == 20) chk("ready_timeout", 64'(in_ready), 64'd1);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1;
    step();
    in_valid = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    step();
    clear = 0;
  endtask

  function automatic logic [63:0] imm_gen(input logic [31:0] w);
    logic [11:0] v;
    case (w[6:0])
      7'b0100011: v = {w[31:25], w[11:7]};
      7'b1100011: v = {w[31], w[7], w[30:25], w[11:8]};
      default:    v = w[31:20];
    endcase
    return {{52{v[11]}}, v};
  endfunction

  function automatic logic [6:0] opc(input logic [2:0] f);
    case (f)
      3'd0: return 7'b0110011;
      3'd1: return 7'b0010011;
      3'd2: return 7'b0000011;
      3'd3: return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  initial begin
    step();
    step();
    chk("rst_we", 64'(mem_we), 0);
    chk("rst_addr", 64'(mem_addr), BASE);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_count", 64'(word_count), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_errcnt", 64'(err_count), 0);
    rst_n = 1;
    step();
    chk("rst_ready", 64'(in_ready), 1);

    b = wd.size();
    send(0, 3, 1, 2, 0, 0, 0);
    send(1, 5, 6, 0, 0, 0, -1);
    send(2, 10, 2, 0, 3, 0, 16);
    step();
    chk("ril_nwr", 64'(wd.size() - b), 3);
    chk("r_word", 64'(wd[b]), 32'h002081B3);
    chk("r_addr", 64'(wa[b]), BASE);
    chk("i_word", 64'(wd[b+1]), 32'hFFF30293);
    chk("i_addr", 64'(wa[b+1]), BASE + 1);
    chk("ld_word", 64'(wd[b+2]), 32'h01013503);
    chk("ld_addr", 64'(wa[b+2]), BASE + 2);
    chk("ril_count", 64'(word_count), 3);

    pulse_clear();
    b = wd.size();
    send(3, 0, 2, 11, 3, 0, 8);
    send(4, 0, 1, 2, 0, 0, -2);
    step();
    chk("sb_nwr", 64'(wd.size() - b), 2);
    chk("st_word", 64'(wd[b]), 32'h00B13423);
    chk("st_addr", 64'(wa[b]), BASE);
    chk("br_word", 64'(wd[b+1]), 32'hFE208EE3);
    chk("br_immgen", imm_gen(wd[b+1]), -64'sd2);
    chk("sb_count", 64'(word_count), 2);

    b = wd.size();
    send(1, 1, 1, 0, 0, 0, 2048);
    send(3, 0, 1, 2, 0, 0, -2049);
    send(6, 1, 1, 1, 0, 0, 0);
    step();
    chk("err_nwr", 64'(wd.size() - b), 0);
    chk("err_flag", 64'(err), 1);
    chk("err_cnt", 64'(err_count), 3);
    chk("err_count_wc", 64'(word_count), 2);
    chk("err_ready", 64'(in_ready), 1);

    pulse_clear();
    chk("clr_err", 64'(err), 0);
    chk("clr_errcnt", 64'(err_count), 0);
    chk("clr_count", 64'(word_count), 0);
    b = wd.size();
    fmt = 1; rd = 1; rs1 = 2; funct3 = 0; imm = 7;
    in_valid = 1;
    repeat (14) step();
    chk("full_nwr", 64'(wd.size() - b), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("full_addr%0d", i), 64'(wa[b+i]), 64'(BASE + i));
    chk("full_flag", 64'(full), 1);
    chk("full_ready", 64'(in_ready), 0);
    chk("full_count", 64'(word_count), 4);
    in_valid = 0;
    pulse_clear();
    chk("refill_count", 64'(word_count), 0);
    chk("refill_full", 64'(full), 0);
    b = wd.size();
    send(1, 4, 4, 0, 0, 0, 1);
    step();
    chk("refill_addr", 64'(wa[b]), BASE);

    b = wd.size();
    fmt = 1; imm = 3;
    clear = 1;
    in_valid = 1;
    step();
    clear = 0;
    in_valid = 0;
    repeat (3) step();
    chk("coll_nwr", 64'(wd.size() - b), 0);
    chk("coll_count", 64'(word_count), 0);

    send(7, 0, 0, 0, 0, 0, 0);
    b = wd.size();
    send(1, 9, 9, 0, 1, 0, 5);
    chk("mid_we_pre", 64'(mem_we), 1);
    rst_n = 0;
    step();
    chk("mid_we", 64'(mem_we), 0);
    chk("mid_addr", 64'(mem_addr), BASE);
    chk("mid_wdata", 64'(mem_wdata), 0);
    chk("mid_count", 64'(word_count), 0);
    chk("mid_full", 64'(full), 0);
    chk("mid_err", 64'(err), 0);
    chk("mid_errcnt", 64'(err_count), 0);
    rst_n = 1;
    step();
    chk("mid_ready", 64'(in_ready), 1);
    chk("mid_nwr", 64'(wd.size() - b), 1);

    repeat (2) begin
      pulse_clear();
      for (int i = 0; i < 4; i++) begin
        logic [2:0] f;
        logic [4:0] d, s1, s2;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [63:0] im;
        int v;
        logic [31:0] w;
        f = 3'($urandom_range(0, 4));
        d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
        f3 = 3'($urandom); f7 = 7'($urandom);
        v = $urandom_range(0, 4095) - 2048;
        im = v;
        b = wd.size();
        send(f, d, s1, s2, f3, f7, im);
        step();
        chk("rnd_nwr", 64'(wd.size() - b), 1);
        w = wd[wd.size()-1];
        chk("rnd_op", 64'(w[6:0]), 64'(opc(f)));
        chk("rnd_rs1", 64'(w[19:15]), 64'(s1));
        chk("rnd_f3", 64'(w[14:12]), 64'(f3));
        if (f == 0) begin
          chk("rnd_rd", 64'(w[11:7]), 64'(d));
          chk("rnd_rs2", 64'(w[24:20]), 64'(s2));
          chk("rnd_f7", 64'(w[31:25]), 64'(f7));
        end else if (f <= 2) begin
          chk("rnd_rd", 64'(w[11:7]), 64'(d));
          chk("rnd_imm", imm_gen(w), im);
        end else begin
          chk("rnd_rs2", 64'(w[24:20]), 64'(s2));
          chk("rnd_imm", imm_gen(w), im);
        end
      end
    end

    step();
    chk("one_cycle_we", 64'(consec), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
